// File: rtl/lsu_mem_arbiter.sv
// Serializes the two LSU lanes onto the single data-RAM port; a same-cycle conflict costs one stall.
// Optional macro LSU_ARB_PERF_EN adds a 32-bit conflict_count output.
module lsu_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_in,
    input  logic          l0_rd_en,
    input  logic          l1_rd_en,
    input  logic          l0_wr_en,
    input  logic          l1_wr_en,
    input  logic [AW-1:0] l0_rd_addr,
    input  logic [AW-1:0] l1_rd_addr,
    input  logic [AW-1:0] l0_wr_addr,
    input  logic [AW-1:0] l1_wr_addr,
    input  logic [DW-1:0] l0_wr_data,
    input  logic [DW-1:0] l1_wr_data,
    input  logic [1:0]    l0_rd_size,
    input  logic [1:0]    l1_rd_size,
    input  logic [1:0]    l0_wr_size,
    input  logic [1:0]    l1_wr_size,
    output logic [DW-1:0] l0_rd_data,
    output logic [DW-1:0] l1_rd_data,
    output logic          ram_rd_en,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_rd_addr,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic [1:0]    ram_rd_size,
    output logic [1:0]    ram_wr_size,
    input  logic [DW-1:0] ram_rd_data,
    output logic          stall_out
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [31:0]   conflict_count
`endif
);

    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        SECOND = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] hold0;
    logic [DW-1:0] hold1;
    logic          hv0;
    logic          hv1;
    logic          l0_was_rd;
    logic          cap1;

    logic req0;
    logic req1;
    logic conflict;
    logic grant0;
    logic grant1;

    assign req0     = l0_rd_en | l0_wr_en;
    assign req1     = l1_rd_en | l1_wr_en;
    assign conflict = (state == FIRST) && req0 && req1;

    // Lane 1 is granted in SECOND even though its request is the held bundle from the conflict cycle.
    assign grant0 = rst && (state == FIRST) && req0;
    assign grant1 = rst && (((state == FIRST) && req1 && !req0) || (state == SECOND));

    assign ram_rd_en   = (grant0 & l0_rd_en) | (grant1 & l1_rd_en);
    assign ram_wr_en   = (grant0 & l0_wr_en) | (grant1 & l1_wr_en);
    assign ram_rd_addr = grant1 ? l1_rd_addr : l0_rd_addr;
    assign ram_wr_addr = grant1 ? l1_wr_addr : l0_wr_addr;
    assign ram_wr_data = grant1 ? l1_wr_data : l0_wr_data;
    assign ram_rd_size = grant1 ? l1_rd_size : l0_rd_size;
    assign ram_wr_size = grant1 ? l1_wr_size : l0_wr_size;

    assign stall_out  = rst && conflict;
    assign l0_rd_data = (rst && hv0) ? hold0 : ram_rd_data;
    assign l1_rd_data = (rst && hv1) ? hold1 : ram_rd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FIRST;
            hold0     <= '0;
            hold1     <= '0;
            hv0       <= 1'b0;
            hv1       <= 1'b0;
            l0_was_rd <= 1'b0;
            cap1      <= 1'b0;
        end else begin
            case (state)
                FIRST: begin
                    // Writeback of the conflicting bundle consumes the held data in this cycle.
                    if (!stall_in) begin
                        hv0 <= 1'b0;
                        hv1 <= 1'b0;
                    end
                    if (req0 && req1) begin
                        l0_was_rd <= l0_rd_en;
                        state     <= SECOND;
                    end
                end
                SECOND: begin
                    if (l0_was_rd) begin
                        hold0 <= ram_rd_data;
                    end
                    hv0   <= l0_was_rd;
                    hv1   <= 1'b0;
                    cap1  <= l1_rd_en;
                    state <= stall_in ? WAIT : FIRST;
                end
                WAIT: begin
                    // Lane 1 load data appears only on the first WAIT cycle, so capture it once.
                    if (cap1) begin
                        hold1 <= ram_rd_data;
                        hv1   <= 1'b1;
                    end
                    cap1 <= 1'b0;
                    if (!stall_in) begin
                        state <= FIRST;
                    end
                end
                default: begin
                    state <= FIRST;
                end
            endcase
        end
    end

`ifdef LSU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_count <= '0;
        end else if (conflict) begin
            conflict_count <= conflict_count + 32'd1;
        end
    end
`endif

endmodule
